// File: rtl/puf_soc_pkg.sv
// puf_soc_pkg: shared types and defaults for the PUF challenge path (CHECK state exists only with PUF_DEFRAMER_PARITY_EN)
package puf_soc_pkg;
  localparam int FRAM_SIZE_DEF = 32;
  localparam int CNT_BIT_SIZE_DEF = 6;
  localparam logic NORM_MOD = 1'b0;
  localparam logic DEBUG_MOD = 1'b1;
`ifdef PUF_DEFRAMER_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, HOLD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;
`endif
endpackage

// File: rtl/puf_chal_deframer_if.sv
// puf_chal_deframer_if: serial rx bus from host plus parallel challenge handshake to the PUF core
interface puf_chal_deframer_if #(parameter int FRAM_SIZE = puf_soc_pkg::FRAM_SIZE_DEF) ();
  logic i_rx_valid;
  logic i_rx_data;
  logic o_rx_ready;
  logic [FRAM_SIZE-1:0] o_chal_data;
  logic o_chal_valid;
  logic i_chal_ready;
  modport master (output i_rx_valid, i_rx_data, i_chal_ready, input o_rx_ready, o_chal_data, o_chal_valid);
  modport slave (input i_rx_valid, i_rx_data, i_chal_ready, output o_rx_ready, o_chal_data, o_chal_valid);
endinterface

// File: rtl/puf_chal_deframer.sv
// puf_chal_deframer: assembles a serial challenge into a FRAM_SIZE-bit frame; PUF_DEFRAMER_PARITY_EN adds a trailing even-parity bit check
module puf_chal_deframer #(
  parameter int FRAM_SIZE = puf_soc_pkg::FRAM_SIZE_DEF,
  parameter int CNT_BIT_SIZE = puf_soc_pkg::CNT_BIT_SIZE_DEF,
  parameter logic NORM_MOD = puf_soc_pkg::NORM_MOD,
  parameter logic DEBUG_MOD = puf_soc_pkg::DEBUG_MOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_op_mode,
  puf_chal_deframer_if.slave bus,
  output logic o_busy,
  output logic o_err
);
  import puf_soc_pkg::*;
  state_t state, state_n;
  logic [CNT_BIT_SIZE-1:0] cnt;
  logic [FRAM_SIZE-1:0] shreg;
  logic mode_q, err_n, accept, last;
  assign accept = bus.i_rx_valid && bus.o_rx_ready;
  assign last = cnt == CNT_BIT_SIZE'(FRAM_SIZE - 1);
  assign bus.o_chal_data = shreg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    err_n = 1'b0;
    bus.o_rx_ready = 1'b0;
    bus.o_chal_valid = 1'b0;
    o_busy = state != IDLE;
    case (state)
      IDLE: state_n = i_start ? RECV : IDLE;
      RECV: begin
        bus.o_rx_ready = 1'b1;
`ifdef PUF_DEFRAMER_PARITY_EN
        if (accept && last) state_n = CHECK;
`else
        if (accept && last) state_n = HOLD;
`endif
      end
`ifdef PUF_DEFRAMER_PARITY_EN
      CHECK: begin
        bus.o_rx_ready = 1'b1;
        if (accept) begin
          state_n = (bus.i_rx_data == ^shreg) ? HOLD : IDLE;
          err_n = bus.i_rx_data != ^shreg;
        end
      end
`endif
      HOLD: begin
        bus.o_chal_valid = 1'b1;
        state_n = bus.i_chal_ready ? IDLE : HOLD;
      end
      default: state_n = IDLE;
    endcase
    if (i_start && state != IDLE) err_n = 1'b1;
  end
  // Shift register only moves in RECV; HOLD and IDLE keep the last frame visible
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      shreg <= '0;
      mode_q <= NORM_MOD;
      o_err <= 1'b0;
    end else begin
      o_err <= err_n;
      if (state == IDLE && i_start) begin
        cnt <= '0;
        shreg <= '0;
        mode_q <= i_op_mode;
      end else if (state == RECV && accept) begin
        cnt <= cnt + CNT_BIT_SIZE'(1);
        shreg <= (mode_q == DEBUG_MOD) ? shreg | (FRAM_SIZE'(bus.i_rx_data) << cnt)
                                       : {shreg[FRAM_SIZE-2:0], bus.i_rx_data};
      end
    end
endmodule

// File: tb/tb_puf_chal_deframer.sv
// tb_puf_chal_deframer: directed frames through an 8-bit deframer, expected frames queued on send and checked on handshake
module tb_puf_chal_deframer;
  localparam int FS = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic i_op_mode = 1'b0;
  logic o_busy, o_err;
  int checks = 0;
  int errors = 0;
  logic [FS-1:0] sb[$];
  always #5 clk = ~clk;
  puf_chal_deframer_if #(.FRAM_SIZE(FS)) bus ();
  puf_chal_deframer #(.FRAM_SIZE(FS), .CNT_BIT_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op_mode(i_op_mode),
    .bus(bus), .o_busy(o_busy), .o_err(o_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [FS-1:0] model(input logic [FS-1:0] seq, input logic mode);
    logic [FS-1:0] r;
    for (int i = 0; i < FS; i++) r[i] = seq[FS-1-i];
    return mode ? r : seq;
  endfunction
  // seq[FS-1] is the first bit on the wire
  task automatic send(input logic [FS-1:0] seq, input logic mode, input int nbits,
                      input bit gap, input int err_at, input bit bad_par);
    i_start = 1'b1;
    i_op_mode = mode;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data = seq[FS-1-i];
      if (i == err_at) begin
        i_start = 1'b1;
        i_op_mode = ~mode;
      end
      @(posedge clk); #1;
      i_start = 1'b0;
      if (i == err_at) chk("err_pulse", o_err, 1);
      if (i == err_at + 1) chk("err_clear", o_err, 0);
      if (gap && i < nbits - 1) begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data = ~bus.i_rx_data;
        @(posedge clk); #1;
      end
    end
`ifdef PUF_DEFRAMER_PARITY_EN
    if (nbits == FS) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data = (^seq) ^ bad_par;
      @(posedge clk); #1;
    end
`endif
    bus.i_rx_valid = 1'b0;
    if (nbits == FS && !bad_par) sb.push_back(model(seq, mode));
  endtask
  task automatic collect(input string tag);
    int n = 0;
    while (bus.o_chal_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, bus.o_chal_valid, 1);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) chk({tag, "_data"}, bus.o_chal_data, sb.pop_front());
    bus.i_chal_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_chal_ready = 1'b0;
    chk({tag, "_idle_busy"}, o_busy, 0);
    chk({tag, "_idle_valid"}, bus.o_chal_valid, 0);
  endtask
  initial begin
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data = 1'b0;
    bus.i_chal_ready = 1'b0;
    #12;
    chk("rst_rx_ready", bus.o_rx_ready, 0);
    chk("rst_valid", bus.o_chal_valid, 0);
    chk("rst_data", bus.o_chal_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'hA5, 1'b0, FS, 1'b0, -1, 1'b0);
    chk("a5_latency", bus.o_chal_valid, 1);
    chk("a5_hold_rx_ready", bus.o_rx_ready, 0);
    collect("a5_norm");
    chk("idle_keeps_data", bus.o_chal_data, 8'hA5);
    send(8'hA5, 1'b1, FS, 1'b0, -1, 1'b0);
    collect("a5_dbg");
    send(8'hC0, 1'b1, FS, 1'b0, -1, 1'b0);
    collect("c0_dbg");
    send(8'h3C, 1'b0, FS, 1'b1, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.o_chal_valid, 1);
      chk("stall_data", bus.o_chal_data, 8'h3C);
      chk("stall_rx_ready", bus.o_rx_ready, 0);
    end
    collect("3c_gap");
    send(8'h96, 1'b0, FS, 1'b0, 3, 1'b0);
    collect("start_in_recv");
    send(8'h5A, 1'b1, FS, 1'b0, -1, 1'b0);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("start_in_hold_err", o_err, 1);
    chk("start_in_hold_valid", bus.o_chal_valid, 1);
    collect("5a_dbg");
    send(8'hF0, 1'b0, 4, 1'b0, -1, 1'b0);
    chk("mid_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_data", bus.o_chal_data, 0);
    chk("mid_rst_rx_ready", bus.o_rx_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_err", o_err, 0);
    send(8'hFF, 1'b0, FS, 1'b0, -1, 1'b0);
    chk("ff_err", o_err, 0);
    collect("ff_after_rst");
`ifdef PUF_DEFRAMER_PARITY_EN
    send(8'hA5, 1'b0, FS, 1'b0, -1, 1'b1);
    chk("par_bad_err", o_err, 1);
    chk("par_bad_valid", bus.o_chal_valid, 0);
    chk("par_bad_busy", o_busy, 0);
    send(8'hA5, 1'b0, FS, 1'b0, -1, 1'b0);
    chk("par_good_err", o_err, 0);
    collect("par_good");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/puf_chal_deframer.md
PUF_CHAL_DEFRAMER -- requirements
Module: puf_chal_deframer

Interface
REQ-001 SHALL have parameter FRAM_SIZE, default 32, challenge frame width in bits.
REQ-002 SHALL have parameter CNT_BIT_SIZE, default 6, bit-counter width; must satisfy 2**CNT_BIT_SIZE > FRAM_SIZE.
REQ-003 SHALL have parameter NORM_MOD, default 1'b0, i_op_mode value selecting MSB-first assembly.
REQ-004 SHALL have parameter DEBUG_MOD, default 1'b1, i_op_mode value selecting LSB-first assembly.
REQ-005 SHALL have port clk  input  1  sole clock; all logic samples on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_start  input  1  one-cycle pulse arming reception of one frame.
REQ-008 SHALL have port i_op_mode  input  1  bit-order select, sampled only with i_start.
REQ-009 SHALL have port i_rx_valid  input  1  serial bit valid from host.
REQ-010 SHALL have port i_rx_data  input  1  serial challenge bit.
REQ-011 SHALL have port o_rx_ready  output  1  deframer accepts a bit this cycle.
REQ-012 SHALL have port o_chal_data  output  FRAM_SIZE  assembled challenge to PUF core.
REQ-013 SHALL have port o_chal_valid  output  1  o_chal_data valid.
REQ-014 SHALL have port i_chal_ready  input  1  PUF core accepts challenge.
REQ-015 SHALL have port o_busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port o_err  output  1  one-cycle error pulse.

Function
REQ-017 SHALL implement FSM states IDLE, RECV, HOLD (plus CHECK when parity compiled in).
REQ-018 IDLE: o_rx_ready=0; i_start=1 -> RECV, latch i_op_mode, clear counter and shift register.
REQ-019 RECV: o_rx_ready=1; a bit is accepted only when i_rx_valid && o_rx_ready.
REQ-020 NORM_MOD: each accepted bit shifts in at LSB, earlier bits move toward MSB (first bit ends at MSB).
REQ-021 DEBUG_MOD: accepted bit k (0-based) is written to position k (first bit ends at LSB).
REQ-022 Counter SHALL increment per accepted bit; on the FRAM_SIZE-th accepted bit -> HOLD (or CHECK).
REQ-023 HOLD: o_chal_valid=1, o_rx_ready=0, o_chal_data stable; i_chal_ready=1 -> IDLE next cycle.
REQ-024 o_chal_valid SHALL rise the cycle after the last bit is accepted (latency 1).
REQ-025 Gaps in i_rx_valid SHALL stall RECV without losing counter or data.
REQ-026 i_start while not IDLE SHALL be ignored and pulse o_err for one cycle.
REQ-027 o_chal_valid and i_chal_ready high in same cycle completes handshake; no back-to-back frames without a new i_start.
REQ-028 o_chal_data SHALL hold last frame value in IDLE until next i_start clears it.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter=0, shift register=0, latched mode=NORM_MOD.
REQ-030 During reset outputs SHALL be o_rx_ready=0, o_chal_valid=0, o_chal_data=0, o_busy=0, o_err=0.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the partial/pending frame with no o_err.

Configuration
REQ-032 Macro PUF_DEFRAMER_PARITY_EN, when defined, SHALL add state CHECK: after FRAM_SIZE data bits one further accepted bit is even parity over the frame.
REQ-033 With PUF_DEFRAMER_PARITY_EN, parity match -> HOLD; mismatch -> IDLE with one-cycle o_err, o_chal_valid never asserted.
REQ-034 Without PUF_DEFRAMER_PARITY_EN, no CHECK state exists and the frame enters HOLD directly after FRAM_SIZE bits.

Structure
REQ-035 State enum, NORM_MOD/DEBUG_MOD and default FRAM_SIZE/CNT_BIT_SIZE SHALL live in puf_soc_pkg.
REQ-036 Single module, no sub-modules; instantiated in puf_soc_top between rx interface and PUF core.

Verification
REQ-037 FRAM_SIZE=8, NORM_MOD, bits 1,0,1,0,0,1,0,1 continuous -> o_chal_data=8'hA5, o_chal_valid one cycle after 8th bit.
REQ-038 FRAM_SIZE=8, DEBUG_MOD, same bit sequence -> o_chal_data=8'hA5 reversed = 8'hA5 (palindrome); repeat with 1,1,0,0,0,0,0,0 -> 8'h03.
REQ-039 i_rx_valid toggling every other cycle during 8'h3C -> o_chal_data=8'h3C, no bit lost or duplicated.
REQ-040 i_chal_ready held low 10 cycles in HOLD -> o_chal_valid and o_chal_data stable, o_rx_ready=0 throughout.
REQ-041 rst_n low after 4 of 8 bits, then new frame 8'hFF -> output 8'hFF, no o_err.
REQ-042 Parity build: 8'hA5 with parity 1 -> o_err pulse, no o_chal_valid; with parity 0 -> valid 8'hA5.
